// File: rtl/axi4_mem_slave_p.sv
// Parametrised AXI4-Lite-style word-addressed memory slave with byte strobes,
// out-of-order AW/W acceptance and SLVERR for addresses at or beyond DEPTH.
module axi4_mem_slave_p #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DEPTH      = 32
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic [ADDR_WIDTH-1:0]     A_W_ADDR,
  input  logic                      A_W_VALID,
  output logic                      A_W_READY,
  input  logic [DATA_WIDTH-1:0]     W_DATA,
  input  logic [DATA_WIDTH/8-1:0]   W_STRB,
  input  logic                      W_VALID,
  output logic                      W_READY,
  output logic [1:0]                B_RESP,
  output logic                      B_VALID,
  input  logic                      B_READY,
  input  logic [ADDR_WIDTH-1:0]     A_R_ADDR,
  input  logic                      A_R_VALID,
  output logic                      A_R_READY,
  output logic [DATA_WIDTH-1:0]     R_DATA,
  output logic [1:0]                R_RESP,
  output logic                      R_VALID,
  input  logic                      R_READY
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_NEED_DATA,
    WR_NEED_ADDR,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

  wr_state_t wr_state;
  rd_state_t rd_state;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] cm_addr;
  logic [DATA_WIDTH-1:0] cm_data;
  logic [STRB_WIDTH-1:0] cm_strb;
  logic                  cm_in_range;
  logic                  ar_in_range;

  // Commit operands come from the live bus or from whichever half was latched earlier.
  always_comb begin
    aw_hs       = A_W_VALID & A_W_READY;
    w_hs        = W_VALID & W_READY;
    ar_hs       = A_R_VALID & A_R_READY;
    cm_addr     = (wr_state == WR_NEED_DATA) ? aw_addr_q : A_W_ADDR;
    cm_data     = (wr_state == WR_NEED_ADDR) ? w_data_q : W_DATA;
    cm_strb     = (wr_state == WR_NEED_ADDR) ? w_strb_q : W_STRB;
    cm_in_range = 64'(cm_addr) < 64'(DEPTH);
    ar_in_range = 64'(A_R_ADDR) < 64'(DEPTH);
    commit      = 1'b0;
    unique case (wr_state)
      WR_IDLE:      commit = aw_hs & w_hs;
      WR_NEED_DATA: commit = w_hs;
      WR_NEED_ADDR: commit = aw_hs;
      WR_RESP:      commit = 1'b0;
      default:      commit = 1'b0;
    endcase
  end

  // Storage has no reset so contents survive RESET_N.
  always_ff @(posedge CLK) begin
    if (commit && cm_in_range) begin
      for (int k = 0; k < int'(STRB_WIDTH); k++) begin
        if (cm_strb[k]) mem[IDX_WIDTH'(cm_addr)][8*k +: 8] <= cm_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_state  <= WR_IDLE;
      A_W_READY <= 1'b0;
      W_READY   <= 1'b0;
      B_VALID   <= 1'b0;
      B_RESP    <= RESP_OKAY;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (commit) begin
      wr_state  <= WR_RESP;
      A_W_READY <= 1'b0;
      W_READY   <= 1'b0;
      B_VALID   <= 1'b1;
      B_RESP    <= cm_in_range ? RESP_OKAY : RESP_SLVERR;
    end else begin
      unique case (wr_state)
        WR_IDLE: begin
          A_W_READY <= 1'b1;
          W_READY   <= 1'b1;
          if (aw_hs) begin
            aw_addr_q <= A_W_ADDR;
            A_W_READY <= 1'b0;
            wr_state  <= WR_NEED_DATA;
          end else if (w_hs) begin
            w_data_q <= W_DATA;
            w_strb_q <= W_STRB;
            W_READY  <= 1'b0;
            wr_state <= WR_NEED_ADDR;
          end
        end
        WR_NEED_DATA, WR_NEED_ADDR: begin
        end
        WR_RESP: begin
          if (B_READY) begin
            B_VALID   <= 1'b0;
            B_RESP    <= RESP_OKAY;
            A_W_READY <= 1'b1;
            W_READY   <= 1'b1;
            wr_state  <= WR_IDLE;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // Read sees pre-commit contents when AR and a write commit share an edge.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_state  <= RD_IDLE;
      A_R_READY <= 1'b0;
      R_VALID   <= 1'b0;
      R_DATA    <= '0;
      R_RESP    <= RESP_OKAY;
    end else begin
      unique case (rd_state)
        RD_IDLE: begin
          A_R_READY <= 1'b1;
          if (ar_hs) begin
            A_R_READY <= 1'b0;
            R_VALID   <= 1'b1;
            R_DATA    <= ar_in_range ? mem[IDX_WIDTH'(A_R_ADDR)] : '0;
            R_RESP    <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
            rd_state  <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (R_READY) begin
            R_VALID   <= 1'b0;
            A_R_READY <= 1'b1;
            rd_state  <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_mem_slave_p.sv
// Bench for axi4_mem_slave_p: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_axi4_mem_slave_p;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 24;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic [AW-1:0] A_W_ADDR = '0;
  logic          A_W_VALID = 1'b0;
  logic          A_W_READY;
  logic [DW-1:0] W_DATA = '0;
  logic [SW-1:0] W_STRB = '0;
  logic          W_VALID = 1'b0;
  logic          W_READY;
  logic [1:0]    B_RESP;
  logic          B_VALID;
  logic          B_READY = 1'b1;
  logic [AW-1:0] A_R_ADDR = '0;
  logic          A_R_VALID = 1'b0;
  logic          A_R_READY;
  logic [DW-1:0] R_DATA;
  logic [1:0]    R_RESP;
  logic          R_VALID;
  logic          R_READY = 1'b1;

  axi4_mem_slave_p #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .A_W_ADDR(A_W_ADDR), .A_W_VALID(A_W_VALID), .A_W_READY(A_W_READY),
    .W_DATA(W_DATA), .W_STRB(W_STRB), .W_VALID(W_VALID), .W_READY(W_READY),
    .B_RESP(B_RESP), .B_VALID(B_VALID), .B_READY(B_READY),
    .A_R_ADDR(A_R_ADDR), .A_R_VALID(A_R_VALID), .A_R_READY(A_R_READY),
    .R_DATA(R_DATA), .R_RESP(R_RESP), .R_VALID(R_VALID), .R_READY(R_READY)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outstanding halves of a write, pending response, pending read data.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_got_a = 0, m_got_w = 0;
  logic [AW-1:0] m_a = '0;
  logic [DW-1:0] m_d = '0;
  logic [SW-1:0] m_s = '0;
  logic          m_awready = 0, m_wready = 0, m_bvalid = 0;
  logic [1:0]    m_bresp = 2'b00;
  logic          m_arready = 0, m_rvalid = 0;
  logic [DW-1:0] m_rdata = '0;
  logic [1:0]    m_rresp = 2'b00;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0;

  always @(posedge CLK or negedge RESET_N) begin : model
    bit aw_hs, w_hs, ar_hs, b_hs, r_hs;
    if (!RESET_N) begin
      m_got_a = 0; m_got_w = 0;
      m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 2'b00;
      m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = 2'b00;
    end else begin
      aw_hs = A_W_VALID && m_awready;
      w_hs  = W_VALID && m_wready;
      ar_hs = A_R_VALID && m_arready;
      b_hs  = B_READY && m_bvalid;
      r_hs  = R_READY && m_rvalid;
      if (r_hs) m_rvalid = 0;
      if (ar_hs) begin
        m_rvalid = 1;
        if (int'(A_R_ADDR) < DEPTH) begin
          m_rdata = m_mem[int'(A_R_ADDR)]; m_rresp = 2'b00;
        end else begin
          m_rdata = '0; m_rresp = 2'b10;
        end
        ar_cnt++;
      end
      m_arready = !m_rvalid;
      if (b_hs) begin m_bvalid = 0; m_bresp = 2'b00; b_cnt++; end
      if (aw_hs) begin m_got_a = 1; m_a = A_W_ADDR; aw_cnt++; end
      if (w_hs) begin m_got_w = 1; m_d = W_DATA; m_s = W_STRB; w_cnt++; end
      if (m_got_a && m_got_w) begin
        if (int'(m_a) < DEPTH) begin
          for (int k = 0; k < SW; k++)
            if (m_s[k]) m_mem[int'(m_a)][8*k +: 8] = m_d[8*k +: 8];
          m_bresp = 2'b00;
        end else begin
          m_bresp = 2'b10;
        end
        m_bvalid = 1; m_got_a = 0; m_got_w = 0;
      end
      m_awready = !m_got_a && !m_bvalid;
      m_wready  = !m_got_w && !m_bvalid;
    end
  end

  always @(negedge CLK) begin : compare
    chk("A_W_READY", 32'(A_W_READY), 32'(m_awready));
    chk("W_READY",   32'(W_READY),   32'(m_wready));
    chk("B_VALID",   32'(B_VALID),   32'(m_bvalid));
    chk("B_RESP",    32'(B_RESP),    32'(m_bresp));
    chk("A_R_READY", 32'(A_R_READY), 32'(m_arready));
    chk("R_VALID",   32'(R_VALID),   32'(m_rvalid));
    chk("R_DATA",    R_DATA,         m_rdata);
    if (m_rvalid) chk("R_RESP", 32'(R_RESP), 32'(m_rresp));
  end

  logic [1:0] wr_bresp;
  logic       mid_awready, mid_wready;

  // Write with W presented `lead` cycles ahead of AW; returns after the B handshake.
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                    input int lead);
    int c_aw = aw_cnt, c_w = w_cnt, c_b = b_cnt, n = 0;
    A_W_ADDR = a; W_DATA = d; W_STRB = s; W_VALID = 1; A_W_VALID = (lead == 0);
    B_READY = 1; wr_bresp = 2'b11;
    while (b_cnt == c_b && n < 40) begin
      @(negedge CLK); n++;
      if (B_VALID) wr_bresp = B_RESP;
      if (n == 1) begin mid_awready = A_W_READY; mid_wready = W_READY; end
      if (w_cnt != c_w) W_VALID = 0;
      if (aw_cnt != c_aw) A_W_VALID = 0;
      else if (n >= lead) A_W_VALID = 1;
    end
    W_VALID = 0; A_W_VALID = 0;
    if (b_cnt == c_b) chk("wr_timeout", 32'(b_cnt - c_b), 1);
  endtask

  // Read: returns outputs seen in the cycle right after the AR handshake.
  task automatic rd(input logic [AW-1:0] a, output logic v, output logic [DW-1:0] d,
                    output logic [1:0] r);
    int c_ar = ar_cnt, n = 0;
    R_READY = 1; A_R_ADDR = a; A_R_VALID = 1;
    while (ar_cnt == c_ar && n < 40) begin @(negedge CLK); n++; end
    A_R_VALID = 0; v = R_VALID; d = R_DATA; r = R_RESP;
    if (ar_cnt == c_ar) chk("rd_timeout", 32'(ar_cnt - c_ar), 1);
    @(negedge CLK);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic          v;
    logic [DW-1:0] d;
    logic [1:0]    r;

    repeat (3) @(negedge CLK);
    chk("rst_awready", 32'(A_W_READY), 0);
    chk("rst_rvalid",  32'(R_VALID),   0);
    RESET_N = 1;
    @(negedge CLK);
    chk("post_rst_awready", 32'(A_W_READY), 1);
    chk("post_rst_wready",  32'(W_READY),   1);
    chk("post_rst_arready", 32'(A_R_READY), 1);

    for (int i = 0; i < DEPTH; i++) wr(AW'(i), $urandom, 4'hF, 0);

    wr(5'd3, 32'hDEADBEEF, 4'hF, 0);
    chk("wr3_bresp", 32'(wr_bresp), 32'h0);
    rd(5'd3, v, d, r);
    chk("rd3_valid", 32'(v), 1);
    chk("rd3_data", d, 32'hDEADBEEF);
    chk("rd3_resp", 32'(r), 0);

    wr(5'd7, 32'h11223344, 4'hF, 2);
    chk("w_first_wready", 32'(mid_wready), 0);
    chk("w_first_awready", 32'(mid_awready), 1);
    rd(5'd7, v, d, r);
    chk("rd7_data", d, 32'h11223344);

    wr(5'd7, 32'hAABBCCDD, 4'b0101, 0);
    rd(5'd7, v, d, r);
    chk("rd7_strb", d, 32'h11BB33DD);

    wr(5'd30, 32'h12121212, 4'hF, 0);
    chk("wr30_bresp", 32'(wr_bresp), 32'h2);
    rd(5'd30, v, d, r);
    chk("rd30_resp", 32'(r), 2);
    chk("rd30_data", d, 0);
    rd(5'd6, v, d, r);

    // Write response backpressure, with further AW/W offered meanwhile.
    B_READY = 0; A_W_ADDR = 5'd5; W_DATA = 32'h0BADF00D; W_STRB = 4'hF;
    A_W_VALID = 1; W_VALID = 1;
    @(negedge CLK);
    A_W_ADDR = 5'd6; W_DATA = 32'hFFFFFFFF;
    repeat (5) begin
      @(negedge CLK);
      chk("bp_bvalid", 32'(B_VALID), 1);
      chk("bp_bresp", 32'(B_RESP), 0);
      chk("bp_awready", 32'(A_W_READY), 0);
      chk("bp_wready", 32'(W_READY), 0);
    end
    A_W_VALID = 0; W_VALID = 0; B_READY = 1;
    @(negedge CLK);
    chk("bp_b_released", 32'(B_VALID), 0);
    @(negedge CLK);

    // Read data backpressure, with another AR offered meanwhile.
    R_READY = 0; A_R_ADDR = 5'd5; A_R_VALID = 1;
    @(negedge CLK);
    A_R_ADDR = 5'd9;
    repeat (5) begin
      @(negedge CLK);
      chk("bp_rvalid", 32'(R_VALID), 1);
      chk("bp_rdata", R_DATA, 32'h0BADF00D);
      chk("bp_rresp", 32'(R_RESP), 0);
      chk("bp_arready", 32'(A_R_READY), 0);
    end
    A_R_VALID = 0; R_READY = 1;
    @(negedge CLK);
    chk("bp_r_released", 32'(R_VALID), 0);
    chk("bp_arready_back", 32'(A_R_READY), 1);

    // Same-edge read and write commit to one word.
    wr(5'd2, 32'h0000AAAA, 4'hF, 0);
    @(negedge CLK);
    A_W_ADDR = 5'd2; W_DATA = 32'h00005555; W_STRB = 4'hF; A_W_VALID = 1; W_VALID = 1;
    A_R_ADDR = 5'd2; A_R_VALID = 1;
    @(negedge CLK);
    A_W_VALID = 0; W_VALID = 0; A_R_VALID = 0;
    chk("rbw_valid", 32'(R_VALID), 1);
    chk("rbw_old", R_DATA, 32'h0000AAAA);
    repeat (2) @(negedge CLK);
    rd(5'd2, v, d, r);
    chk("rbw_new", d, 32'h00005555);

    // Reset while waiting for write data.
    wr(5'd4, 32'h12345678, 4'hF, 0);
    @(negedge CLK);
    A_W_ADDR = 5'd4; A_W_VALID = 1; W_DATA = 32'hCAFEBABE; W_VALID = 0;
    @(negedge CLK);
    A_W_VALID = 0;
    chk("nd_awready", 32'(A_W_READY), 0);
    chk("nd_wready", 32'(W_READY), 1);
    #2 RESET_N = 0;
    #1;
    chk("arst_awready", 32'(A_W_READY), 0);
    chk("arst_wready", 32'(W_READY), 0);
    chk("arst_bvalid", 32'(B_VALID), 0);
    chk("arst_arready", 32'(A_R_READY), 0);
    chk("arst_rdata", R_DATA, 0);
    W_VALID = 1;
    @(negedge CLK);
    W_VALID = 0; RESET_N = 1;
    @(negedge CLK);
    rd(5'd4, v, d, r);
    chk("rst_mem_kept", d, 32'h12345678);

    // Randomized traffic on both channels.
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      A_W_VALID = ($urandom_range(0, 2) == 0);
      A_W_ADDR  = AW'($urandom_range(0, 31));
      W_VALID   = ($urandom_range(0, 2) == 0);
      W_DATA    = $urandom;
      W_STRB    = SW'($urandom);
      B_READY   = ($urandom_range(0, 3) != 0);
      A_R_VALID = ($urandom_range(0, 1) == 0);
      A_R_ADDR  = AW'($urandom_range(0, 31));
      R_READY   = ($urandom_range(0, 3) != 0);
    end
    @(negedge CLK);
    A_W_VALID = 0; W_VALID = 0; A_R_VALID = 0; B_READY = 1; R_READY = 1;
    repeat (5) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi4_mem_slave_p.md
Name: axi4_mem_slave_p

Overview:
- Parametrised AXI4-Lite-style memory slave; successor to the fixed 16x32 slave.
- Independent read and write channels.
- Adds:
  - generic data width and depth
  - byte write strobes
  - write address and write data accepted in either order
  - SLVERR responses for out-of-range addresses
  - a 2-bit read response
- Sits behind the master/interconnect as a register-file/scratch memory target.

Parameters:
DATA_WIDTH, 32, data bus width in bits; multiple of 8, min 8
ADDR_WIDTH, 5, word-address width (address = word index, not byte)
DEPTH, 32, number of implemented words; 1 <= DEPTH <= 2**ADDR_WIDTH

Ports:
CLK  in  1  single clock, rising edge
RESET_N  in  1  asynchronous, active-low reset
A_W_ADDR  in  ADDR_WIDTH  write word address
A_W_VALID  in  1  write address valid
A_W_READY  out  1  slave accepts write address
W_DATA  in  DATA_WIDTH  write data
W_STRB  in  DATA_WIDTH/8  byte enables, bit k covers W_DATA[8k+7:8k]
W_VALID  in  1  write data valid
W_READY  out  1  slave accepts write data
B_RESP  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
B_VALID  out  1  write response valid
B_READY  in  1  master accepts write response
A_R_ADDR  in  ADDR_WIDTH  read word address
A_R_VALID  in  1  read address valid
A_R_READY  out  1  slave accepts read address
R_DATA  out  DATA_WIDTH  read data
R_RESP  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR
R_VALID  out  1  read data valid
R_READY  in  1  master accepts read data

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (RESET_N=0, any time, including mid-transaction):
  - all outputs 0; both FSMs to idle; partial captures discarded.
  - memory array is NOT cleared; uncommitted writes never reach memory.
- All outputs are registered. Handshake = VALID&READY sampled at a rising edge.
- Write FSM, states WR_IDLE / WR_NEED_DATA / WR_NEED_ADDR / WR_RESP:
  - WR_IDLE: A_W_READY=1, W_READY=1. Both are first set on the first edge after reset release.
  - AW and W handshake on the same edge: commit, go to WR_RESP.
  - AW only: latch address, drop A_W_READY, go to WR_NEED_DATA (W_READY stays 1).
  - W only: latch data and strobe, drop W_READY, go to WR_NEED_ADDR (A_W_READY stays 1).
  - WR_NEED_DATA / WR_NEED_ADDR: on the missing handshake, commit and go to WR_RESP.
  - Commit edge:
    - address < DEPTH: each byte with W_STRB=1 is written; other bytes unchanged. B_RESP=00.
    - address >= DEPTH: no memory change, B_RESP=10.
    - W_STRB=0: no change, B_RESP=00.
    - A_W_READY=W_READY=0 and B_VALID=1 from the commit edge onward.
  - WR_RESP: B_VALID and B_RESP held stable until B_READY. On the B handshake edge: B_VALID=0, B_RESP=00, A_W_READY=W_READY=1, back to WR_IDLE.
  - Back-to-back: next write can be accepted the cycle after the B handshake.
- Read FSM, states RD_IDLE / RD_DATA:
  - RD_IDLE: A_R_READY=1.
  - On the AR handshake edge:
    - A_R_READY=0 and R_VALID=1.
    - R_DATA=memory[addr] with R_RESP=00, or R_DATA=0 with R_RESP=10 if addr >= DEPTH.
    - Latency: data valid the cycle after the AR handshake.
  - RD_DATA: R_DATA, R_RESP, R_VALID held stable until R_READY. On the R handshake edge: R_VALID=0, A_R_READY=1, back to RD_IDLE. R_DATA retains its last value.
- Simultaneous events:
  - Read and write channels are fully concurrent.
  - AR handshake on the same edge as a write commit to the same word: read returns the OLD data (read-before-write).
- Address bits are used unmodified; no wrap-around. Out-of-range never aliases.

Test Plan:
- Defaults (DATA_WIDTH=32, ADDR_WIDTH=5, DEPTH=32): A_W_ADDR=3 and W_DATA=32'hDEADBEEF, W_STRB=4'hF same cycle, B_READY=1 -> B_VALID 1 cycle after commit with B_RESP=00. Then read addr 3 with R_READY=1 -> R_VALID one cycle after AR handshake, R_DATA=32'hDEADBEEF, R_RESP=00.
- Ordering: W (32'h11223344, STRB=4'hF) to addr 7 two cycles before AW -> W_READY low after W handshake, A_W_READY still 1. Commit occurs on the AW edge; readback of addr 7 = 32'h11223344.
- Strobes: addr 7 holds 32'h11223344; write 32'hAABBCCDD with W_STRB=4'b0101 -> readback 32'h11BB33DD.
- DEPTH=24: write addr 30 -> B_RESP=10, memory unchanged. Read addr 30 -> R_RESP=10, R_DATA=0.
- Backpressure: B_READY=0 for 5 cycles, then R_READY=0 for 5 cycles -> B_VALID/B_RESP and R_VALID/R_DATA/R_RESP stable throughout; no new AW/W/AR accepted (readies 0) until the respective handshake.
- Same-edge AR and write commit to addr 2 (old 32'h0000AAAA, new 32'h5555): R_DATA=32'h0000AAAA; a subsequent read returns 32'h00005555. Also: RESET_N pulsed low while in WR_NEED_DATA -> all outputs 0 immediately; memory at the latched address unchanged.
